fetch_sequencer: RTL and testbench

Instruction-fetch controller for the RV32 core. It owns the fetch PC and issues one word request at a time to instruction memory. Fetched words go into a small {pc, instr} buffer. The buffer feeds decode through a valid/ready handshake, and an execute-stage branch redirects fetch and discards stale work. It replaces the free-running PC with busy/branch control at the front of the pipeline.

---
 rtl/fetch_sequencer_pkg.sv | 25 ++
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer_fetch_buffer.sv | 92 +++++++++
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_sequencer_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response and decode-side handshake of the fetch sequencer.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_4;
  logic [XLEN-1:0] if_instr;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output if_valid, if_pc, if_pc_4, if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  if_valid, if_pc, if_pc_4, if_instr,
    output if_ready
  );

endinterface

// File: rtl/fetch_sequencer_fetch_buffer.sv
// {pc, instr} FIFO with flush and registered head outputs toward decode.
module fetch_sequencer_fetch_buffer
  import fetch_sequencer_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  fetch_entry_t      push_entry,
  input  logic              pop_ready,
  output logic [CNT_W-1:0]  count,
  output logic              head_valid,
  output logic [XLEN-1:0]   head_pc,
  output logic [XLEN-1:0]   head_pc_4,
  output logic [XLEN-1:0]   head_instr
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;
  logic             head_load;
  fetch_entry_t     head_next;

  assign do_push    = push & ~flush;
  assign do_pop     = head_valid & pop_ready & ~flush;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  // Next head: the entry behind the popped one, or the incoming word when it lands at the front.
  always_comb begin
    head_load = 1'b0;
    head_next = mem[rd_ptr_inc];
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
    if (do_pop) begin
      if (count > CNT_W'(1)) begin
        head_load = 1'b1;
        head_next = mem[rd_ptr_inc];
      end else if (do_push) begin
        head_load = 1'b1;
        head_next = push_entry;
      end
    end else if (do_push && (count == '0)) begin
      head_load = 1'b1;
      head_next = push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_pc    <= '0;
      head_pc_4  <= '0;
      head_instr <= '0;
    end else begin
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_pop)  rd_ptr <= rd_ptr_inc;
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (head_load) begin
        head_pc    <= head_next.pc;
        head_pc_4  <= head_next.pc + PC_STEP;
        head_instr <= head_next.instr;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: issues one imem word request at a time, handles redirects, feeds the buffer.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              branch,
  input  logic [XLEN-1:0]   pc_forbranch,
  fetch_sequencer_if.master bus
);

  localparam int unsigned      CNT_W   = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  state_t           state;
  state_t           state_next;
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  fetch_pc_next;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  branch_target;
  logic             req_valid;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_after;
  fetch_entry_t     push_entry;

  assign branch_target = word_align(pc_forbranch);
  assign accept        = (state == S_REQ) & bus.imem_req_ready;
  assign pop           = bus.if_valid & bus.if_ready;
  assign count_after   = count + CNT_W'(1) - CNT_W'(pop);
  assign push_entry    = '{pc: out_pc, instr: bus.imem_rsp_data};

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;

  // Next state and fetch PC; a redirect overrides any increment on the same edge.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    push          = 1'b0;
    case (state)
      S_IDLE: begin
        if (branch || (count < DEPTH_C)) state_next = S_REQ;
      end
      S_REQ: begin
        if (bus.imem_req_ready) begin
          fetch_pc_next = fetch_pc + PC_STEP;
          state_next    = branch ? S_DROP : S_WAIT;
        end else if (branch) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (branch) begin
            state_next = S_IDLE;
          end else begin
            push       = 1'b1;
            state_next = (count_after < DEPTH_C) ? S_REQ : S_IDLE;
          end
        end else if (branch) begin
          state_next = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.imem_rsp_valid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (branch) fetch_pc_next = branch_target;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      out_pc    <= '0;
      req_valid <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      req_valid <= (state_next == S_REQ);
      if (accept) out_pc <= fetch_pc;
    end
  end

  fetch_sequencer_fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (branch),
    .push       (push),
    .push_entry (push_entry),
    .pop_ready  (bus.if_ready),
    .count      (count),
    .head_valid (bus.if_valid),
    .head_pc    (bus.if_pc),
    .head_pc_4  (bus.if_pc_4),
    .head_instr (bus.if_instr)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: imem model, reference fetch address, decode-side checks.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mem_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] pc_forbranch = '0;

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_accept = 0;
  int          extra_lat = 0;
  logic [31:0] model_addr = RST_PC;
  logic [31:0] cur_pc = '0;
  bit          cur_stale = 1'b1;
  exp_t        exp_q[$];
  mem_t        mem_q[$];

  fetch_sequencer_if bus();

  fetch_sequencer #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .branch       (branch),
    .pc_forbranch (pc_forbranch),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A00_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    check_eq({tag, "_req_addr"},  bus.imem_req_addr, RST_PC);
    check_eq({tag, "_if_valid"},  32'(bus.if_valid), 32'd0);
    check_eq({tag, "_if_pc"},     bus.if_pc, 32'd0);
    check_eq({tag, "_if_pc_4"},   bus.if_pc_4, 32'd0);
    check_eq({tag, "_if_instr"},  bus.if_instr, 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at the negedge before the edge on which a request is accepted.
  task automatic wait_accept(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) seen = 1'b1;
    end
    check_eq({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_if_valid(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.if_valid) seen = 1'b1;
    end
    check_eq({tag, "_timeout"}, 32'(seen), 32'd1);
  endtask

  // imem: answers each accepted request after 1 + extra_lat cycles.
  initial begin : imem_model
    mem_t m;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      bus.imem_rsp_valid = 1'b0;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        m = mem_q.pop_front();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = instr_of(m.addr);
        cur_pc    = m.addr;
        cur_stale = m.stale;
      end
    end
  end

  // Reference model evaluated mid-cycle for the events of the coming edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset_n) begin
      exp_q.delete();
      model_addr = RST_PC;
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      cur_stale = 1'b1;
    end else begin
      if (bus.if_valid && bus.if_ready && !branch) begin
        check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("if_pc",    bus.if_pc,    e.pc);
          check_eq("if_pc_4",  bus.if_pc_4,  e.pc + 32'd4);
          check_eq("if_instr", bus.if_instr, e.instr);
        end
      end
      if (bus.imem_rsp_valid && !cur_stale && !branch) begin
        exp_q.push_back('{pc: cur_pc, instr: bus.imem_rsp_data});
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check_eq("req_addr", bus.imem_req_addr, model_addr);
        mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + 1 + extra_lat, stale: branch});
        model_addr = model_addr + 32'd4;
        n_accept++;
      end
      if (branch) begin
        exp_q.delete();
        foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        cur_stale  = 1'b1;
        model_addr = {pc_forbranch[31:2], 2'b00};
      end
    end
  end

  initial begin : stimulus
    int a;
    int b;
    int snap;
    bit seen;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b0;

    wait_cycles(3);
    check_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // First fetch latency and back-to-back rate with decode stalled.
    wait_accept("acc0");
    a = cyc;
    @(posedge clk); #1;
    check_eq("lat_accept_edge_valid", 32'(bus.if_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("lat_push_edge_valid", 32'(bus.if_valid), 32'd1);
    check_eq("lat_if_pc",   bus.if_pc,   32'h0);
    check_eq("lat_if_pc_4", bus.if_pc_4, 32'h4);
    wait_accept("acc4");
    b = cyc;
    check_eq("acc4_addr", bus.imem_req_addr, 32'h4);
    check_eq("fetch_rate", 32'(b - a), 32'd2);

    // Buffer full: no requests, head held.
    wait_cycles(6);
    check_eq("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check_eq("full_if_valid",  32'(bus.if_valid), 32'd1);
    check_eq("full_head_pc",   bus.if_pc, 32'h0);
    snap = n_accept;
    wait_cycles(4);
    check_eq("full_no_accept", 32'(n_accept), 32'(snap));
    bus.if_ready = 1'b1;
    wait_accept("resume");
    check_eq("resume_addr", bus.imem_req_addr, 32'h8);

    // Redirect while waiting; late response must be dropped.
    wait_cycles(5);
    extra_lat = 1;
    wait_accept("bw_acc");
    @(posedge clk); #1;
    pc_forbranch = 32'h0000_0100;
    branch = 1'b1;
    @(posedge clk); #1;
    branch = 1'b0;
    extra_lat = 0;
    check_eq("bw_flush_valid", 32'(bus.if_valid), 32'd0);
    wait_accept("bw_redir");
    check_eq("bw_redir_addr", bus.imem_req_addr, 32'h0000_0100);

    // Withdraw a pending request with an unaligned target.
    wait_cycles(4);
    bus.imem_req_ready = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 32 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.imem_req_valid) seen = 1'b1;
    end
    check_eq("wd_req_timeout", 32'(seen), 32'd1);
    pc_forbranch = 32'h0000_0203;
    branch = 1'b1;
    @(posedge clk); #1;
    branch = 1'b0;
    check_eq("wd_idle", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_req_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("wd_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check_eq("wd_req_addr",  bus.imem_req_addr, 32'h0000_0200);

    // Redirect in the same cycle as the response.
    wait_cycles(3);
    wait_accept("br_rsp_acc");
    @(posedge clk); #1;
    pc_forbranch = 32'h0000_0400;
    branch = 1'b1;
    @(posedge clk); #1;
    branch = 1'b0;
    wait_if_valid("br_rsp_valid");
    check_eq("br_rsp_head_pc", bus.if_pc, 32'h0000_0400);

    // Asynchronous reset while a response is outstanding.
    wait_cycles(3);
    extra_lat = 2;
    wait_accept("rst_acc");
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (4) @(posedge clk);
    extra_lat = 0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_accept("rst_restart");
    check_eq("rst_restart_addr", bus.imem_req_addr, RST_PC);

    // PC wrap at the top of the address space.
    wait_cycles(3);
    pc_forbranch = 32'hFFFF_FFFC;
    branch = 1'b1;
    @(posedge clk); #1;
    branch = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.if_valid && bus.if_pc == 32'hFFFF_FFFC) seen = 1'b1;
    end
    check_eq("wrap_head_timeout", 32'(seen), 32'd1);
    check_eq("wrap_if_pc_4", bus.if_pc_4, 32'h0);
    wait_accept("wrap_next");
    check_eq("wrap_next_addr", bus.imem_req_addr, 32'h0);

    wait_cycles(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
